// File: rtl/gate_vector_checker.sv
// Clocked stimulus/response checker for a two-input basic-gate block: sweeps a/b over 00..11,
// samples g_in after a settle delay and accumulates mismatch status. Option: GATE_CHK_STOP_ON_FAIL_EN.
module gate_vector_checker #(
    parameter int SETTLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic [4:0]       g_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [4:0]       fail_mask,
    output logic             first_fail_valid,
    output logic [1:0]       first_fail_idx
);
    // state  | meaning
    // IDLE   | waiting for start after reset
    // APPLY  | vector driven, settle counter loaded
    // SETTLE | waiting for the gate outputs to settle
    // SAMPLE | g_in compared against the golden truth table
    // DONE   | sweep finished, results held until the next start
    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;

    localparam int S_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CNT_W = (S_EFF > 1) ? $clog2(S_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(S_EFF - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic [1:0]       ab_q;
    logic             busy_q, done_q, pass_q, ffv_q;
    logic [ERR_W-1:0] err_q;
    logic [4:0]       mask_q;
    logic [1:0]       ffi_q;

    logic [4:0]       exp_d, mis_d, mask_d;
    logic [ERR_W-1:0] err_d;
    logic             stop_d;

    always_comb begin
        exp_d  = {ab_q[1] ^ ab_q[0], ~(ab_q[1] | ab_q[0]), ~(ab_q[1] & ab_q[0]),
                  ab_q[1] | ab_q[0], ab_q[1] & ab_q[0]};
        mis_d  = g_in ^ exp_d;
        mask_d = mask_q | mis_d;
        err_d  = err_q;
        if (mis_d != 5'd0 && err_q != ERR_MAX)
            err_d = err_q + ERR_W'(1);
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        stop_d = (mis_d != 5'd0);
`else
        stop_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            ab_q    <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            mask_q  <= 5'd0;
            ffv_q   <= 1'b0;
            ffi_q   <= 2'd0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= APPLY;
                        idx_q   <= 2'd0;
                        ab_q    <= 2'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        mask_q  <= 5'd0;
                        ffv_q   <= 1'b0;
                        ffi_q   <= 2'd0;
                    end
                end
                APPLY: begin
                    cnt_q   <= CNT_LOAD;
                    state_q <= SETTLE;
                end
                SETTLE: begin
                    if (cnt_q == '0)
                        state_q <= SAMPLE;
                    else
                        cnt_q <= cnt_q - CNT_W'(1);
                end
                SAMPLE: begin
                    err_q  <= err_d;
                    mask_q <= mask_d;
                    if (mis_d != 5'd0 && !ffv_q) begin
                        ffv_q <= 1'b1;
                        ffi_q <= idx_q;
                    end
                    if (idx_q == 2'd3 || stop_d) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == '0);
                        // a stopped sweep keeps the failing vector on a/b for debug
                        if (!stop_d)
                            ab_q <= 2'd0;
                    end else begin
                        state_q <= APPLY;
                        idx_q   <= idx_q + 2'd1;
                        ab_q    <= idx_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_out            = ab_q[1];
    assign b_out            = ab_q[0];
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign fail_mask        = mask_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffi_q;
endmodule

// File: tb/tb_gate_vector_checker.sv
// Randomized bench for gate_vector_checker: a faulty-gate model drives g_in and a sweep-level
// reference model predicts timing and results for an ERR_W=8 and an ERR_W=1 instance.
module tb_gate_vector_checker;
    localparam int S = 4;
    localparam int P = S + 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] g_in = 5'd0;

    logic       a_out, b_out, busy, done, pass, ffv;
    logic [7:0] err_count;
    logic [4:0] fail_mask;
    logic [1:0] ffi;

    logic       a1, b1, busy1, done1, pass1, ffv1;
    logic [0:0] err1;
    logic [4:0] mask1;
    logic [1:0] ffi1;

    gate_vector_checker #(.SETTLE_CYCLES(S), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(a_out), .b_out(b_out), .g_in(g_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_mask(fail_mask),
        .first_fail_valid(ffv), .first_fail_idx(ffi));

    gate_vector_checker #(.SETTLE_CYCLES(S), .ERR_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(a1), .b_out(b1), .g_in(g_in),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_mask(mask1),
        .first_fail_valid(ffv1), .first_fail_idx(ffi1));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Fault model of the gate block: stuck-at-0, stuck-at-1 and inverted output bits.
    logic [4:0] stk0 = 5'd0, stk1 = 5'd0, inv = 5'd0;

    function automatic logic [4:0] gold(input int k);
        int ones;
        ones = (k >> 1) + (k & 1);
        return {ones == 1, ones == 0, ones != 2, ones >= 1, ones == 2};
    endfunction

    function automatic logic [4:0] faulty(input int k);
        return ((gold(k) & ~stk0) | stk1) ^ inv;
    endfunction

    task automatic sweep(input int ign_t, input int abort_t);
        int         nerr, ffi_e, last, done_t, k;
        bit         ffv_e, stopped;
        logic [4:0] m_e, mis;
        nerr = 0; ffi_e = 0; last = 0; ffv_e = 0; stopped = 0; m_e = 5'd0;
        for (int v = 0; v < 4; v++) begin
            last = v;
            mis  = faulty(v) ^ gold(v);
            if (mis != 5'd0) begin
                nerr++;
                m_e |= mis;
                if (!ffv_e) begin ffv_e = 1; ffi_e = v; end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
                stopped = 1;
                break;
`endif
            end
        end
        done_t = (last + 1) * P;

        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int t = 0; t < done_t; t++) begin
            k = t / P;
            check("busy", busy, 1);
            check("done_early", done, 0);
            check("ab_seq", {a_out, b_out}, k[1:0]);
            if (t == 0)
                check("clr_on_start", {pass, err_count, fail_mask, ffv, ffi}, 0);
            g_in = (t % P == P - 1) ? faulty(k) : 5'($urandom);
            if (t == ign_t) start = 1'b1;
            if (t == abort_t) begin
                #2 rst_n = 1'b0;
                #1;
                check("async_rst", {a_out, b_out, busy, done, pass, err_count, fail_mask, ffv, ffi}, 0);
                check("async_rst1", {a1, b1, busy1, done1, pass1, err1, mask1, ffv1, ffi1}, 0);
                @(negedge clk) rst_n = 1'b1;
                return;
            end
            @(posedge clk);
            #1 start = 1'b0;
        end
        check("done", done, 1);
        check("busy_end", busy, 0);
        check("pass", pass, nerr == 0);
        check("err_count", err_count, nerr);
        check("fail_mask", fail_mask, m_e);
        check("ff_valid", ffv, ffv_e);
        check("ff_idx", ffi, ffi_e);
        check("ab_end", {a_out, b_out}, stopped ? last : 0);
        check("done1", done1, 1);
        check("err_sat1", err1, (nerr > 0) ? 1 : 0);
        check("pass1", pass1, nerr == 0);
        check("mask1", mask1, m_e);
    endtask

    initial begin
        #12;
        check("reset", {a_out, b_out, busy, done, pass, err_count, fail_mask, ffv, ffi}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle", {busy, done}, 0);

        sweep(-1, -1);                              // clean gates
        stk0 = 5'b10000; sweep(-1, -1);             // XOR stuck at 0
        stk0 = 5'd0; sweep(2 * P - 1, -1);          // start during SAMPLE of idx 1, restart from DONE
        inv = 5'b11111; sweep(-1, -1);              // every output inverted
        inv = 5'd0; sweep(-1, 2 * P + 2);           // reset during SETTLE of idx 2
        sweep(-1, -1);
        stk1 = 5'b00010; sweep(-1, -1);             // OR stuck at 1
        stk1 = 5'd0;
        for (int r = 0; r < 20; r++) begin
            stk0 = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
            stk1 = ($urandom_range(0, 2) == 0) ? 5'($urandom) & ~stk0 : 5'd0;
            inv  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            sweep(-1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/gate_vector_checker.md
Name: gate_vector_checker

Overview:
Self-checking stimulus and response stage for the two-input basic-gate block. It drives a/b through the four input combinations 00, 01, 10, 11 in that order. After a programmable settle time it samples the five gate outputs and compares them against the golden truth table. It accumulates error status, and replaces hand-written initial-block stimulus so that gate blocks can be checked in clocked regression and on hardware.

Parameters:
SETTLE_CYCLES, 4, cycles between driving a vector and sampling g_in; values below 1 behave as 1.
ERR_W, 8, width of the saturating mismatch counter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to run a full sweep; honoured only in IDLE or DONE.
a_out  output  1  gate input a (vector MSB).
b_out  output  1  gate input b (vector LSB).
g_in  input  5  gate outputs; g_in[0]=g1 AND, [1]=g2 OR, [2]=g3 NAND, [3]=g4 NOR, [4]=g5 XOR.
busy  output  1  high while a sweep is in progress.
done  output  1  high from sweep completion until the next accepted start or reset.
pass  output  1  high together with done when err_count==0; low otherwise.
err_count  output  ERR_W  number of mismatching vectors, saturating at 2^ERR_W-1.
fail_mask  output  5  sticky OR of per-bit mismatches over the sweep.
first_fail_valid  output  1  a mismatch has been recorded in this sweep.
first_fail_idx  output  2  vector index {a,b} of the first mismatch.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: a_out, b_out, busy, done, pass, err_count, fail_mask, first_fail_valid, first_fail_idx.
- Reset asserted mid-sweep aborts immediately to the reset values. No partial result is retained.
- States and transitions:
  - IDLE: start=1 -> APPLY.
  - APPLY: 1 cycle.
  - SETTLE: SETTLE_CYCLES cycles, via a down-counter loaded in APPLY.
  - SAMPLE: 1 cycle.
  - After SAMPLE: idx<3 -> APPLY with idx+1; idx==3 -> DONE.
  - DONE: start=1 -> APPLY.
- Accepting start (in IDLE or DONE):
  - Clears idx, err_count, fail_mask, first_fail_valid and first_fail_idx.
  - Deasserts done and pass.
  - Sets busy in the same edge.
- start in APPLY, SETTLE or SAMPLE is ignored.
- Vector index idx is 2 bits: a_out=idx[1], b_out=idx[0].
  - a_out/b_out are registered and change only on entry to APPLY.
  - They hold stable through APPLY, SETTLE and SAMPLE.
  - They return to 0 on entry to DONE.
- Golden value: exp = {a^b, ~(a|b), ~(a&b), a|b, a&b}, matching the g_in bit order above.
- In SAMPLE: mis = g_in ^ exp, using the currently driven a/b.
  - If mis!=0: err_count increments (saturating), fail_mask |= mis.
  - If first_fail_valid was 0, first_fail_idx=idx and first_fail_valid=1.
- Latency: a sweep takes exactly 4*(SETTLE_CYCLES+2) cycles from the start-accepting edge to the edge that sets done. With the default this is 24.
- On entry to DONE: busy=0, done=1, pass=(err_count==0). Both are evaluated with the final SAMPLE's update included.
- g_in is only examined in SAMPLE. Glitches during SETTLE are ignored.

Optional Feature:
Macro GATE_CHK_STOP_ON_FAIL_EN.
- Defined: the first mismatching SAMPLE moves directly to DONE.
  - err_count=1, pass=0.
  - a_out/b_out are not cleared and keep the failing vector for debug.
  - Sweep length is shortened accordingly.
- Undefined: all four vectors always run, and the behaviour is as above.

Test Plan:
- Correct gate model on g_in, SETTLE_CYCLES=4, start pulse -> a/b sequence 00,01,10,11, each held 6 cycles. done=1 and pass=1 exactly 24 cycles after start; err_count=0, fail_mask=0, first_fail_valid=0.
- g_in[4] stuck at 0 -> mismatches at idx 1 and 2. err_count=2, fail_mask=5'b10000, first_fail_idx=1, pass=0.
- rst_n pulled low during SETTLE of idx 2 -> all outputs 0 asynchronously. A new start then runs a full 24-cycle sweep from idx 0.
- start pulsed during SAMPLE of idx 1 -> ignored, and done still arrives at cycle 24. start pulsed in DONE -> done and pass clear, err_count clears, a new sweep begins.
- ERR_W=1 with all outputs inverted -> err_count saturates at 1, fail_mask=5'b11111, first_fail_idx=0.
- GATE_CHK_STOP_ON_FAIL_EN defined, g_in[1] stuck at 1 -> stops at idx 0 after 6 cycles. done=1, err_count=1, a_out=b_out=0, fail_mask=5'b00010.
